// File: rtl/divide.sv
// Sequential signed integer divider (radix-2 restoring on magnitudes).
// Produces one quotient bit per clock with a single operation in flight.
// The quotient and remainder truncate toward zero, so the remainder takes the sign of the dividend.
`timescale 1ns/1ps

module divide #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [N_WIDTH-1:0] in_N,
  input  logic signed [D_WIDTH-1:0] in_D,
  output logic                      out_valid,
  output logic signed [N_WIDTH-1:0] out_Q,
  output logic signed [D_WIDTH-1:0] out_R,
  output logic                      out_dbz,
  output logic                      out_ovf
);

  localparam int CNT_W = (N_WIDTH > 2) ? $clog2(N_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [N_WIDTH-1:0]   nmag_q, nmag_d;      // |N|, shifted left; quotient bits enter at the LSB
  logic [D_WIDTH-1:0]   dmag_q, dmag_d;      // |D|
  logic [D_WIDTH:0]     rem_q, rem_d;        // partial remainder, one bit wider than |D|
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dbz_q, dbz_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [N_WIDTH-1:0]   out_q_q, out_q_d;
  logic [D_WIDTH-1:0]   out_r_q, out_r_d;
  logic                 out_dbz_q, out_dbz_d;
  logic                 out_ovf_q, out_ovf_d;

  // Operand magnitudes; the most-negative value maps onto 2^(W-1), which still fits unsigned.
  logic [N_WIDTH-1:0]   n_abs;
  logic [D_WIDTH-1:0]   d_abs;
  // Trial subtraction helpers for one restoring step.
  logic [D_WIDTH+1:0]   rem_shift;
  logic                 sub_ok;
  logic [D_WIDTH:0]     rem_sub;

  // Magnitudes of the incoming operands and the per-cycle trial subtraction.
  always_comb begin
    n_abs     = in_N[N_WIDTH-1] ? (~in_N) + N_WIDTH'(1) : in_N;
    d_abs     = in_D[D_WIDTH-1] ? (~in_D) + D_WIDTH'(1) : in_D;
    rem_shift = {rem_q, nmag_q[N_WIDTH-1]};
    sub_ok    = (rem_shift >= {2'b00, dmag_q});
    rem_sub   = rem_shift[D_WIDTH:0] - {1'b0, dmag_q};
  end

  // Next-state logic for the control FSM, the datapath and the registered outputs.
  always_comb begin
    state_d     = state_q;
    nmag_d      = nmag_q;
    dmag_d      = dmag_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_q_d     = out_q_q;
    out_r_d     = out_r_q;
    out_dbz_d   = out_dbz_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          nmag_d  = n_abs;
          dmag_d  = d_abs;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = in_N[N_WIDTH-1] ^ in_D[D_WIDTH-1];
          rneg_d  = in_N[N_WIDTH-1];
          dbz_d   = (in_D == '0);
          ovf_d   = (in_N == {1'b1, {(N_WIDTH-1){1'b0}}}) && (in_D == '1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d  = sub_ok ? rem_sub : rem_shift[D_WIDTH:0];
        nmag_d = {nmag_q[N_WIDTH-2:0], sub_ok};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_WIDTH-1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        out_valid_d = 1'b1;
        out_dbz_d   = dbz_q;
        out_ovf_d   = ovf_q;
        if (dbz_q) begin
          // Division by zero reports an all-ones quotient and a zero remainder.
          out_q_d = '1;
          out_r_d = '0;
        end else begin
          // The overflow case needs no special path: |Q| = 2^(N_WIDTH-1) with a positive sign wraps to the most-negative value.
          out_q_d = qneg_q ? (~nmag_q) + N_WIDTH'(1) : nmag_q;
          out_r_d = rneg_q ? (~rem_q[D_WIDTH-1:0]) + D_WIDTH'(1) : rem_q[D_WIDTH-1:0];
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered so that it stays low throughout reset and rises on the first edge after release.
    ready_d = (state_d == IDLE);
  end

  // State registers; an asserted reset aborts any operation in flight immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      nmag_q      <= '0;
      dmag_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_r_q     <= '0;
      out_dbz_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      nmag_q      <= nmag_d;
      dmag_q      <= dmag_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_r_q     <= out_r_d;
      out_dbz_q   <= out_dbz_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign out_Q     = out_q_q;
  assign out_R     = out_r_q;
  assign out_dbz   = out_dbz_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_divide.sv
// Directed and randomised checks for the sequential signed divider.
`timescale 1ns/1ps

module tb_divide;
  localparam int NW  = 16;
  localparam int DW  = 16;
  localparam int LAT = NW + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [NW-1:0] in_N;
  logic signed [DW-1:0] in_D;
  logic                 out_valid;
  logic signed [NW-1:0] out_Q;
  logic signed [DW-1:0] out_R;
  logic                 out_dbz;
  logic                 out_ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  divide #(.N_WIDTH(NW), .D_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_N      (in_N),
    .in_D      (in_D),
    .out_valid (out_valid),
    .out_Q     (out_Q),
    .out_R     (out_R),
    .out_dbz   (out_dbz),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for its result; returns with the result cycle current.
  task automatic run_op(input int n, input int d, output int q, output int r,
                        output int dbz, output int ovf, output int lat);
    int w;
    int busy_rdy;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("ready_wait", longint'(in_ready), 1);
    in_N     = NW'(n);
    in_D     = DW'(d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    busy_rdy = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_rdy++;
      tick();
      lat++;
    end
    chk("busy_ready_low", busy_rdy, 0);
    chk("ready_at_valid", longint'(in_ready), 1);
    q   = out_Q;
    r   = out_R;
    dbz = out_dbz;
    ovf = out_ovf;
  endtask

  task automatic op_check(input string tag, input int n, input int d,
                          input int eq, input int er, input int edbz, input int eovf);
    int q, r, dbz, ovf, lat;
    run_op(n, d, q, r, dbz, ovf, lat);
    $display("op %s: %0d / %0d -> Q=%0d R=%0d dbz=%0d ovf=%0d lat=%0d", tag, n, d, q, r, dbz, ovf, lat);
    chk({tag, "_q"},   q,   eq);
    chk({tag, "_r"},   r,   er);
    chk({tag, "_dbz"}, dbz, edbz);
    chk({tag, "_ovf"}, ovf, eovf);
    chk({tag, "_lat"}, lat, LAT);
  endtask

  // Directed operand tables with hand-computed results.
  int sn[4]  = '{100, -100, 100, -100};
  int sd[4]  = '{7, 7, -7, -7};
  int sq[4]  = '{14, -14, -14, 14};
  int sr[4]  = '{2, -2, 2, -2};

  int bn[3]  = '{77, -1000, 32767};
  int bd[3]  = '{5, 33, -2};
  int bq[3]  = '{15, -30, -16383};
  int br[3]  = '{2, -10, 1};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, r, dbz, ovf, lat;
    int acc_c[3];
    int out_c[3];
    int ai, oi, cyc, rdy, stray;
    logic [15:0] rv;
    int n, d, eq, er, eovf;

    // Reset state.
    reset    = 1'b0;
    in_valid = 1'b0;
    in_N     = '0;
    in_D     = '0;
    repeat (3) tick();
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_q",     longint'(out_Q), 0);
    chk("rst_r",     longint'(out_R), 0);
    chk("rst_dbz",   longint'(out_dbz), 0);
    chk("rst_ovf",   longint'(out_ovf), 0);
    chk("rst_ready", longint'(in_ready), 0);
    #2 reset = 1'b1;
    tick();
    chk("rel_ready", longint'(in_ready), 1);

    // Sign combinations.
    for (int i = 0; i < 4; i++) begin
      op_check($sformatf("sign%0d", i), sn[i], sd[i], sq[i], sr[i], 0, 0);
    end
    tick();
    chk("valid_pulse", longint'(out_valid), 0);
    chk("hold_q", longint'(out_Q), 14);
    chk("hold_r", longint'(out_R), -2);

    // Limits.
    op_check("ovf",    -32768, -1,     -32768, 0, 0, 1);
    op_check("minpos", -32768, 1,      -32768, 0, 0, 0);
    op_check("mind",   5,      -32768, 0,      5, 0, 0);

    // Divide by zero, then a normal op clears the flag.
    op_check("dbz",   1234, 0, -1, 0, 1, 0);
    op_check("after", 9,    3, 3,  0, 0, 0);

    // Back-to-back with in_valid held high.
    ai    = 0;
    oi    = 0;
    cyc   = 0;
    stray = 0;
    in_N     = NW'(bn[0]);
    in_D     = DW'(bd[0]);
    in_valid = 1'b1;
    while (oi < 3 && cyc < 100) begin
      rdy = in_ready;
      tick();
      cyc++;
      if (in_ready && !out_valid) stray++;
      if (rdy && ai < 3) begin
        acc_c[ai] = cyc;
        ai++;
        if (ai < 3) begin
          in_N = NW'(bn[ai]);
          in_D = DW'(bd[ai]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        $display("b2b %0d: Q=%0d R=%0d at cycle %0d", oi, out_Q, out_R, cyc);
        chk($sformatf("b2b%0d_q", oi),   longint'(out_Q), bq[oi]);
        chk($sformatf("b2b%0d_r", oi),   longint'(out_R), br[oi]);
        chk($sformatf("b2b%0d_lat", oi), cyc - acc_c[oi], LAT);
        out_c[oi] = cyc;
        oi++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_results", oi, 3);
    chk("b2b_accepts", ai, 3);
    chk("b2b_busy_ready", stray, 0);
    for (int k = 1; k < 3; k++) begin
      chk($sformatf("b2b_gap%0d", k), acc_c[k] - out_c[k-1], 1);
    end

    // Reset in the middle of an operation.
    tick();
    in_N     = NW'(1000);
    in_D     = DW'(3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("abort_valid", longint'(out_valid), 0);
    chk("abort_q",     longint'(out_Q), 0);
    chk("abort_r",     longint'(out_R), 0);
    chk("abort_ready", longint'(in_ready), 0);
    tick();
    tick();
    #2 reset = 1'b1;
    stray = 0;
    tick();
    chk("abort_rel_ready", longint'(in_ready), 1);
    for (int i = 0; i < 25; i++) begin
      if (out_valid) stray++;
      tick();
    end
    chk("abort_no_valid", stray, 0);
    op_check("redo", 1000, 3, 333, 1, 0, 0);

    // Random pairs with a non-zero divisor against the language's own division.
    for (int i = 0; i < 2000; i++) begin
      rv = 16'($urandom);
      n  = int'($signed(rv));
      if ($urandom_range(1, 0) == 1) begin
        d = int'($urandom_range(20, 1));
        if ($urandom_range(1, 0) == 1) d = -d;
      end else begin
        do begin
          rv = 16'($urandom);
        end while (rv == 16'h0000);
        d = int'($signed(rv));
      end
      if (i == 0) begin
        n = -32768;
        d = -1;
      end
      eovf = (n == -32768 && d == -1) ? 1 : 0;
      eq   = eovf ? -32768 : n / d;
      er   = n % d;
      run_op(n, d, q, r, dbz, ovf, lat);
      $display("rnd %0d: %0d / %0d -> Q=%0d R=%0d", i, n, d, q, r);
      chk("rnd_q",   q,   eq);
      chk("rnd_r",   r,   er);
      chk("rnd_ovf", ovf, eovf);
      chk("rnd_dbz", dbz, 0);
      chk("rnd_lat", lat, LAT);
      if (!eovf) chk("rnd_ident", q * d + r, n);
      if (r != 0) chk("rnd_rsign", (r < 0) ? 1 : 0, (n < 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
